// File: rtl/log_alog_pkg.sv
// log_alog_pkg: shared widths and constants for the Mitchell log2/antilog2 unit.
package log_alog_pkg;
    localparam int FRAC_W = 12;
    localparam int LOG_IN_W = 16;
    localparam int A18_IN_W = 18;
    localparam int A19_IN_W = 19;
    localparam int LOG_INT_OFFSET = 12;
    localparam logic [18:0] LOG2_24 = 19'h0495C;
    // 1.0 in the antilog output formats (1.18 and 1.19)
    localparam logic [18:0] ONE_1P18 = 19'h40000;
    localparam logic [19:0] ONE_1P19 = 20'h80000;
endpackage

// File: rtl/log_alog_unit_if.sv
// log_alog_if: operand and result bundle for the three log/antilog channels.
import log_alog_pkg::*;

interface log_alog_if;
    logic [LOG_IN_W-1:0] log_data;
    logic [4:0]          log_intgr;
    logic [FRAC_W-1:0]   log_frac;
    logic                log_valid;
    logic [A18_IN_W-1:0] a18_data;
    logic [A18_IN_W:0]   a18_out;
    logic [A19_IN_W-1:0] a19_data;
    logic [A19_IN_W:0]   a19_out;
    modport master (output log_data, a18_data, a19_data,
                    input  log_intgr, log_frac, log_valid, a18_out, a19_out);
    modport slave  (input  log_data, a18_data, a19_data,
                    output log_intgr, log_frac, log_valid, a18_out, a19_out);
endinterface

// File: rtl/log_alog_unit_alog_core.sv
// alog_core: combinational Mitchell 2^x; overflow saturates when LOG_ALOG_SAT_EN is defined, else wraps.
import log_alog_pkg::*;

module alog_core #(
    parameter int IN_W  = 18,
    parameter int OUT_W = IN_W + 1
) (
    input  logic [IN_W-1:0]  data,
    output logic [OUT_W-1:0] res
);
    localparam int IW = IN_W - FRAC_W;
    logic signed [IW-1:0] i;
    logic [IW-1:0] n;
    logic [OUT_W-1:0] mant;
    always_comb begin
        i = data[IN_W-1:FRAC_W];
        n = -i;
        mant = {1'b1, data[FRAC_W-1:0], {(OUT_W-1-FRAC_W){1'b0}}};
`ifdef LOG_ALOG_SAT_EN
        res = i[IW-1] ? mant >> n : (i == '0 ? mant : '1);
`else
        res = i[IW-1] ? mant >> n : mant << i;
`endif
    end
endmodule

// File: rtl/log_alog_unit.sv
// log_alog_unit: registered Mitchell log2 (4.12) and two antilog2 channels; LOG_ALOG_SAT_EN saturates antilog overflow.
import log_alog_pkg::*;

module log_alog_unit (
    input logic clk,
    input logic reset,
    log_alog_if.slave bus
);
    logic [3:0] k;
    logic [FRAC_W-1:0] frac_next;
    logic [A18_IN_W:0] a18_next;
    logic [A19_IN_W:0] a19_next;
    // shifting left by 16-k drops the leading one and MSB-aligns the bits below it
    always_comb begin
        k = '0;
        for (int j = 0; j < LOG_IN_W; j++) k = bus.log_data[j] ? 4'(j) : k;
        frac_next = FRAC_W'((bus.log_data << (5'd16 - {1'b0, k})) >> 4);
    end
    alog_core #(.IN_W(A18_IN_W), .OUT_W(A18_IN_W + 1)) u_a18 (.data(bus.a18_data), .res(a18_next));
    alog_core #(.IN_W(A19_IN_W), .OUT_W(A19_IN_W + 1)) u_a19 (.data(bus.a19_data), .res(a19_next));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.log_valid <= 1'b0;
            bus.log_intgr <= '0;
            bus.log_frac  <= '0;
            bus.a18_out   <= '0;
            bus.a19_out   <= '0;
        end else begin
            bus.log_valid <= |bus.log_data;
            bus.log_intgr <= |bus.log_data ? 5'(k) - 5'(LOG_INT_OFFSET) : '0;
            bus.log_frac  <= frac_next;
            bus.a18_out   <= a18_next;
            bus.a19_out   <= a19_next;
        end
    end
endmodule

// File: tb/tb_log_alog_unit.sv
// tb_log_alog_unit: scoreboard bench comparing log_alog_unit against an arithmetic reference model.
module tb_log_alog_unit;
    typedef struct packed {
        logic [4:0]  li;
        logic [11:0] lf;
        logic        lv;
        logic [18:0] a18;
        logic [19:0] a19;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t e;
    exp_t got;

    log_alog_if io ();
    log_alog_unit dut (.clk(clk), .reset(reset), .bus(io));

    always #5 clk = ~clk;

    // 2^(i + f/4096) in Mitchell form, scaled to an ob-bit 1.(ob-1) output
    function automatic logic [63:0] alog_ref(int i, int f, int ob);
        logic [63:0] m = 64'(4096 + f) << (ob - 13);
        logic [63:0] lim = (64'd1 << ob) - 1;
        if (i <= 0) return (-i >= 64) ? 64'd0 : m >> (-i);
`ifdef LOG_ALOG_SAT_EN
        return lim;
`else
        return (m << i) & lim;
`endif
    endfunction

    function automatic exp_t model(logic [15:0] d, logic [17:0] a, logic [18:0] b);
        exp_t r;
        int kk = 0;
        r = '0;
        if (d != 0) begin
            while ((32'd1 << (kk + 1)) <= 32'(d)) kk++;
            r.lv = 1'b1;
            r.li = 5'(kk - 12);
            r.lf = 12'(((longint'(d) - (longint'(1) << kk)) * 4096) >> kk);
        end
        r.a18 = 19'(alog_ref(int'($signed(a[17:12])), int'(a[11:0]), 19));
        r.a19 = 20'(alog_ref(int'($signed(b[18:12])), int'(b[11:0]), 20));
        return r;
    endfunction

    task automatic issue(logic [15:0] l, logic [17:0] a, logic [18:0] b);
        @(negedge clk);
        io.log_data = l;
        io.a18_data = a;
        io.a19_data = b;
        q.push_back(model(l, a, b));
    endtask

    task automatic check_zero(string name);
        got = '{io.log_intgr, io.log_frac, io.log_valid, io.a18_out, io.a19_out};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: outputs %h required all zero", name, got);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset) q.delete();
        else if (q.size() > 0) begin
            e = q.pop_front();
            got = '{io.log_intgr, io.log_frac, io.log_valid, io.a18_out, io.a19_out};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL result: got intgr=%h frac=%h valid=%b a18=%h a19=%h, need intgr=%h frac=%h valid=%b a18=%h a19=%h",
                         got.li, got.lf, got.lv, got.a18, got.a19, e.li, e.lf, e.lv, e.a18, e.a19);
            end
        end
    end

    logic [15:0] log_v [6] = '{16'h1000, 16'h3244, 16'h0001, 16'hFFFF, 16'h0000, 16'h0800};
    logic [17:0] a18_v [6] = '{18'h00000, 18'h00800, 18'h3F000, 18'h3F800, 18'h2D000, 18'h01000};
    logic [18:0] a19_v [6] = '{19'h00000, 19'h7B6A4, 19'h7F000, 19'h01000, 19'h6C000, 19'h00800};

    initial begin
        io.log_data = '0;
        io.a18_data = '0;
        io.a19_data = '0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");
        @(negedge clk);
        reset = 0;
        for (int n = 0; n < 6; n++) issue(log_v[n], a18_v[n], a19_v[n]);
        for (int n = 0; n < 150; n++)
            issue(($urandom % 8 == 0) ? 16'h0 : 16'($urandom) >> $urandom_range(0, 15),
                  ($urandom % 2 == 0) ? 18'($urandom) : {6'($urandom_range(0, 63) - 32 | 32), 12'($urandom)},
                  19'($urandom));
        // in-flight operand must be discarded by a mid-cycle asynchronous reset
        @(negedge clk);
        io.log_data = 16'hFFFF;
        io.a18_data = 18'h00800;
        io.a19_data = 19'h00000;
        #2 reset = 1;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        reset = 0;
        for (int n = 0; n < 6; n++) issue(log_v[5 - n], a18_v[n], a19_v[5 - n]);
        for (int n = 0; n < 100; n++) issue(16'($urandom), 18'($urandom), 19'($urandom));
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, need 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
